vrased_reset_seq: RTL and testbench

- Downstream of the VRASED monitor. Consumes its registered violation reset plus the per-check violation flags, and produces a stretched, glitch-free PUC request to the openMSP430 core.
- Latches the violation cause and the violating PC, and keeps a saturating violation counter, so post-reset attestation software can read why the device was reset.
- Sits between the monitor's reset output and the core's PUC/reset input.

---
 rtl/vrased_defs.sv | 27 ++
 rtl/vrased_sat_counter.sv | 20 ++
 rtl/vrased_reset_seq.sv | 118 +++++++++++
 tb/tb_vrased_reset_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vrased_defs.sv
// rtl/vrased_defs.sv - shared state encoding and cause bit indices for the VRASED reset sequencer
package vrased_defs;

  typedef logic [1:0] seq_state_t;

  // Episode states; puc_req is asserted in HOLD and DRAIN only
  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_HOLD  = 2'd1;
  localparam seq_state_t ST_DRAIN = 2'd2;
  localparam seq_state_t ST_QUIET = 2'd3;

  // Bit positions of the monitor's per-check violation flags
  localparam int CAUSE_XSTACK    = 0;
  localparam int CAUSE_AC        = 1;
  localparam int CAUSE_ATOMIC    = 2;
  localparam int CAUSE_DMAAC     = 3;
  localparam int CAUSE_DMADETECT = 4;
  localparam int CAUSE_DMAXSTACK = 5;

  localparam int NCAUSE_DEF = 6;

  // Timer reload value for an n-cycle interval counted down to zero
  function automatic logic [7:0] timer_load(input int n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/vrased_sat_counter.sv
// rtl/vrased_sat_counter.sv - saturating up-counter for the violation episode count
module vrased_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count up on inc, sticking at all-ones until reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/vrased_reset_seq.sv
// rtl/vrased_reset_seq.sv - stretches VRASED violation resets into a glitch-free PUC request and latches status
module vrased_reset_seq
  import vrased_defs::*;
#(
  parameter int HOLD_CYCLES  = 8,
  parameter int QUIET_CYCLES = 4,
  parameter int CNT_W        = 8,
  parameter int NCAUSE       = NCAUSE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vrased_reset,
  input  logic [NCAUSE-1:0] cause_in,
  input  logic [15:0]       pc,
  input  logic              clr_status,
  output logic              puc_req,
  output logic              busy,
  output logic [NCAUSE-1:0] cause_latched,
  output logic [15:0]       viol_pc,
  output logic [CNT_W-1:0]  viol_count
);

  localparam logic [7:0] HOLD_LOAD  = timer_load(HOLD_CYCLES);
  localparam logic [7:0] QUIET_LOAD = timer_load(QUIET_CYCLES);

  seq_state_t        state, state_nxt;
  logic [7:0]        timer, timer_nxt;
  logic [NCAUSE-1:0] cause_nxt;
  logic [15:0]       pc_nxt;
  logic              episode_start;

  // Next-state, timer and status-latch decisions for the episode FSM.
  // When HOLD expires with the violation already gone, DRAIN has nothing to
  // wait for, so the FSM steps straight to QUIET and puc_req stays high for
  // exactly HOLD_CYCLES; DRAIN is only occupied while vrased_reset persists.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    cause_nxt     = cause_latched;
    pc_nxt        = viol_pc;
    episode_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vrased_reset) begin
          state_nxt     = ST_HOLD;
          timer_nxt     = HOLD_LOAD;
          cause_nxt     = cause_in;
          pc_nxt        = pc;
          episode_start = 1'b1;
        end else if (clr_status) begin
          cause_nxt = '0;
          pc_nxt    = '0;
        end
      end
      ST_HOLD: begin
        cause_nxt = cause_latched | cause_in;
        if (timer == 8'd0) begin
          if (vrased_reset) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_QUIET;
            timer_nxt = QUIET_LOAD;
          end
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      ST_DRAIN: begin
        cause_nxt = cause_latched | cause_in;
        if (!vrased_reset) begin
          state_nxt = ST_QUIET;
          timer_nxt = QUIET_LOAD;
        end
      end
      ST_QUIET: begin
        if (vrased_reset) begin
          state_nxt = ST_HOLD;
          timer_nxt = HOLD_LOAD;
          cause_nxt = cause_latched | cause_in;
        end else if (timer == 8'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Register state, timer, status and the decoded outputs so puc_req and busy come straight from flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      timer         <= 8'd0;
      puc_req       <= 1'b0;
      busy          <= 1'b0;
      cause_latched <= '0;
      viol_pc       <= 16'd0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      puc_req       <= (state_nxt == ST_HOLD) || (state_nxt == ST_DRAIN);
      busy          <= (state_nxt != ST_IDLE);
      cause_latched <= cause_nxt;
      viol_pc       <= pc_nxt;
    end
  end

  vrased_sat_counter #(
    .W(CNT_W)
  ) u_viol_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (episode_start),
    .value  (viol_count)
  );

endmodule

// File: tb/tb_vrased_reset_seq.sv
// tb/tb_vrased_reset_seq.sv - self-checking bench for vrased_reset_seq
module tb_vrased_reset_seq;

  localparam int H = 8;
  localparam int Q = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vrased_reset = 1'b0;
  logic [5:0]  cause_in = 6'd0;
  logic [15:0] pc = 16'd0;
  logic        clr_status = 1'b0;

  logic        puc_req, busy, puc_req2, busy2;
  logic [5:0]  cause_latched, cause_latched2;
  logic [15:0] viol_pc, viol_pc2;
  logic [7:0]  viol_count;
  logic [1:0]  viol_count2;

  vrased_reset_seq #(.HOLD_CYCLES(H), .QUIET_CYCLES(Q), .CNT_W(8), .NCAUSE(6)) dut (
    .clk(clk), .reset_n(reset_n), .vrased_reset(vrased_reset), .cause_in(cause_in), .pc(pc),
    .clr_status(clr_status), .puc_req(puc_req), .busy(busy), .cause_latched(cause_latched),
    .viol_pc(viol_pc), .viol_count(viol_count)
  );

  vrased_reset_seq #(.HOLD_CYCLES(H), .QUIET_CYCLES(Q), .CNT_W(2), .NCAUSE(6)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .vrased_reset(vrased_reset), .cause_in(cause_in), .pc(pc),
    .clr_status(clr_status), .puc_req(puc_req2), .busy(busy2), .cause_latched(cause_latched2),
    .viol_pc(viol_pc2), .viol_count(viol_count2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: phase of the episode plus cycles remaining in that phase
  typedef enum int {M_REST, M_PULSE, M_EXTEND, M_COOL} mphase_t;
  mphase_t     m_ph = M_REST;
  int          m_rem = 0;
  logic [5:0]  m_cause = 6'd0;
  logic [15:0] m_pc = 16'd0;
  int          m_cnt = 0;

  typedef struct {
    logic        vr;
    logic [5:0]  c;
    logic [15:0] p;
    logic        cl;
    logic        e_puc;
    logic        e_busy;
    logic [5:0]  e_cause;
    logic [15:0] e_pc;
    logic [7:0]  e_cnt;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = M_REST; m_rem = 0; m_cause = 6'd0; m_pc = 16'd0; m_cnt = 0;
  endtask

  task automatic model_edge();
    case (m_ph)
      M_REST: begin
        if (vrased_reset) begin
          m_ph = M_PULSE; m_rem = H; m_cause = cause_in; m_pc = pc; m_cnt++;
        end else if (clr_status) begin
          m_cause = 6'd0; m_pc = 16'd0;
        end
      end
      M_PULSE: begin
        m_cause = m_cause | cause_in;
        m_rem--;
        if (m_rem == 0) begin
          if (vrased_reset) m_ph = M_EXTEND;
          else begin m_ph = M_COOL; m_rem = Q; end
        end
      end
      M_EXTEND: begin
        m_cause = m_cause | cause_in;
        if (!vrased_reset) begin m_ph = M_COOL; m_rem = Q; end
      end
      M_COOL: begin
        if (vrased_reset) begin
          m_ph = M_PULSE; m_rem = H; m_cause = m_cause | cause_in;
        end else begin
          m_rem--;
          if (m_rem == 0) m_ph = M_REST;
        end
      end
      default: m_ph = M_REST;
    endcase
  endtask

  task automatic check_all();
    chk("puc", 32'(puc_req), 32'((m_ph == M_PULSE) || (m_ph == M_EXTEND)));
    chk("busy", 32'(busy), 32'(m_ph != M_REST));
    chk("cause", 32'(cause_latched), 32'(m_cause));
    chk("vpc", 32'(viol_pc), 32'(m_pc));
    chk("cnt", 32'(viol_count), 32'((m_cnt > 255) ? 255 : m_cnt));
    chk("cnt_w2", 32'(viol_count2), 32'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  task automatic tick(input logic v, input logic [5:0] c, input logic [15:0] p, input logic cl);
    vrased_reset = v; cause_in = c; pc = p; clr_status = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 6'd0, 16'h0F0F, 1'b0);
  endtask

  task automatic do_reset();
    vrased_reset = 1'b0; cause_in = 6'd0; pc = 16'd0; clr_status = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic v;
    logic [7:0] sat_exp [5];

    for (int i = 0; i < 14; i++) begin
      tbl[i].vr      = (i == 0);
      tbl[i].c       = (i == 0) ? 6'b000100 : 6'b000000;
      tbl[i].p       = (i == 0) ? 16'hE010 : 16'h1234;
      tbl[i].cl      = (i == 13);
      tbl[i].e_puc   = (i <= 7);
      tbl[i].e_busy  = (i <= 11);
      tbl[i].e_cause = (i == 13) ? 6'b000000 : 6'b000100;
      tbl[i].e_pc    = (i == 13) ? 16'h0000 : 16'hE010;
      tbl[i].e_cnt   = 8'd1;
    end
    sat_exp[0] = 8'd1; sat_exp[1] = 8'd2; sat_exp[2] = 8'd3; sat_exp[3] = 8'd3; sat_exp[4] = 8'd3;

    do_reset();
    chk("rst_puc", 32'(puc_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cause", 32'(cause_latched), 32'd0);
    chk("rst_vpc", 32'(viol_pc), 32'd0);
    chk("rst_cnt", 32'(viol_count), 32'd0);

    // Single pulse episode followed by a status clear in IDLE
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].vr, tbl[i].c, tbl[i].p, tbl[i].cl);
      chk($sformatf("tbl%0d_puc", i), 32'(puc_req), 32'(tbl[i].e_puc));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_cause", i), 32'(cause_latched), 32'(tbl[i].e_cause));
      chk($sformatf("tbl%0d_vpc", i), 32'(viol_pc), 32'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_cnt", i), 32'(viol_count), 32'(tbl[i].e_cnt));
    end

    // Long violation with an extra flag pulsed on its fourth cycle
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, (i == 3) ? 6'b010001 : 6'b000001, 16'hC000, 1'b0);
    chk("long_puc", 32'(puc_req), 32'd1);
    idle(1);
    chk("long_drop", 32'(puc_req), 32'd0);
    chk("long_cause", 32'(cause_latched), 32'(6'b010001));
    chk("long_cnt", 32'(viol_count), 32'd1);
    idle(6);

    // Re-trigger two cycles into QUIET stays in the same episode
    do_reset();
    tick(1'b1, 6'b000010, 16'hE100, 1'b0);
    idle(9);
    chk("q_busy", 32'(busy), 32'd1);
    chk("q_puc", 32'(puc_req), 32'd0);
    n = 0;
    tick(1'b1, 6'b001000, 16'hE200, 1'b0);
    if (puc_req) n++;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      if (puc_req) n++;
    end
    chk("q_relen", 32'(n), 32'd8);
    chk("q_cnt", 32'(viol_count), 32'd1);
    chk("q_vpc", 32'(viol_pc), 32'hE100);
    chk("q_cause", 32'(cause_latched), 32'(6'b001010));
    idle(10);
    tick(1'b1, 6'b000001, 16'hBEEF, 1'b0);
    chk("new_cnt", 32'(viol_count), 32'd2);
    chk("new_vpc", 32'(viol_pc), 32'hBEEF);

    // clr_status in IDLE, during HOLD, and together with a violation
    idle(20);
    tick(1'b0, 6'd0, 16'h0, 1'b1);
    chk("clr_cause", 32'(cause_latched), 32'd0);
    chk("clr_vpc", 32'(viol_pc), 32'd0);
    chk("clr_cnt", 32'(viol_count), 32'd2);
    tick(1'b1, 6'b000100, 16'h1111, 1'b0);
    tick(1'b0, 6'd0, 16'h0, 1'b1);
    chk("clrhold_cause", 32'(cause_latched), 32'(6'b000100));
    chk("clrhold_vpc", 32'(viol_pc), 32'h1111);
    idle(20);
    tick(1'b1, 6'b100000, 16'h2222, 1'b1);
    chk("clrvr_cause", 32'(cause_latched), 32'(6'b100000));
    chk("clrvr_vpc", 32'(viol_pc), 32'h2222);
    chk("clrvr_cnt", 32'(viol_count), 32'd4);

    // Asynchronous reset between clock edges in the middle of HOLD
    idle(20);
    tick(1'b1, 6'b000011, 16'h3333, 1'b0);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_puc", 32'(puc_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cause", 32'(cause_latched), 32'd0);
    chk("arst_vpc", 32'(viol_pc), 32'd0);
    chk("arst_cnt", 32'(viol_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all();
    tick(1'b1, 6'b000001, 16'hABCD, 1'b0);
    chk("arst_new_cnt", 32'(viol_count), 32'd1);
    chk("arst_new_vpc", 32'(viol_pc), 32'hABCD);

    // Narrow counter saturates after three episodes
    do_reset();
    for (int e = 0; e < 5; e++) begin
      tick(1'b1, 6'b000001, 16'(16'h4000 + e), 1'b0);
      chk($sformatf("sat_w2_%0d", e), 32'(viol_count2), 32'(sat_exp[e]));
      idle(14);
    end

    // Randomized traffic against the model
    do_reset();
    v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      n = int'($urandom_range(0, 19));
      v = (n < 2) || ((n < 12) && v);
      tick(v, v ? 6'($urandom) : 6'd0, 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
